// File: rtl/systolic_pkg.sv
// -----------------------------------------------------------------------------
// systolic_pkg
//   Shared declarations for the systolic multiplier and its result serializer.
//   - ser_state_t : serializer FSM states (IDLE, STREAM)
//   - idx_width   : index width for a SIZE-wide dimension, never below 1 bit
// -----------------------------------------------------------------------------
package systolic_pkg;

   typedef enum logic {
      IDLE   = 1'b0,
      STREAM = 1'b1
   } ser_state_t;

   // Width of a row/column index: max(1, clog2(n)).
   function automatic int idx_width(input int n);
      return (n > 2) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/matrix_result_serializer.sv
// -----------------------------------------------------------------------------
// matrix_result_serializer
//   Captures a SIZE x SIZE result matrix from the systolic multiplier on a
//   one-cycle strobe and streams it out element by element in row-major order
//   over a valid/ready interface.
//
// Ports
//   clock      : rising-edge clock
//   nreset     : asynchronous active-low reset
//   capture_i  : result-ready strobe; matrix_i is sampled when it is accepted
//   matrix_i   : result matrix, matrix_i[row][col] is one WIDTH-bit element
//   m_valid_o  : output element valid (high exactly while streaming)
//   m_ready_i  : downstream ready
//   m_data_o   : current element
//   m_row_o    : row index of m_data_o
//   m_col_o    : column index of m_data_o
//   m_last_o   : high on element (SIZE-1, SIZE-1)
//   busy_o     : high while streaming
//   overrun_o  : one-cycle pulse when a capture is dropped
//   state_o    : debug view of the FSM state (0 = IDLE, 1 = STREAM)
//
// Handshake: a beat transfers on a rising edge where m_valid_o and m_ready_i
// are both high. m_valid_o comes straight from the state register, so it never
// depends on m_ready_i; while m_valid_o is high and m_ready_i is low, data,
// indices and m_last_o hold.
// -----------------------------------------------------------------------------
module matrix_result_serializer
   import systolic_pkg::*;
#(
   parameter int WIDTH = 4,
   parameter int SIZE  = 2
) (
   input  logic                                    clock,
   input  logic                                    nreset,
   input  logic                                    capture_i,
   input  logic [SIZE-1:0][SIZE-1:0][WIDTH-1:0]    matrix_i,
   output logic                                    m_valid_o,
   input  logic                                    m_ready_i,
   output logic [WIDTH-1:0]                        m_data_o,
   output logic [idx_width(SIZE)-1:0]              m_row_o,
   output logic [idx_width(SIZE)-1:0]              m_col_o,
   output logic                                    m_last_o,
   output logic                                    busy_o,
   output logic                                    overrun_o,
   output logic                                    state_o
);

   localparam int            IW       = idx_width(SIZE);
   localparam logic [IW-1:0] LAST_IDX = IW'(SIZE - 1);

   ser_state_t                            state_q, state_n;
   logic [SIZE-1:0][SIZE-1:0][WIDTH-1:0]  buffer_q;
   logic [IW-1:0]                         row_q, row_n;
   logic [IW-1:0]                         col_q, col_n;
   logic [WIDTH-1:0]                      data_q, data_n;
   logic                                  last_q, last_n;
   logic                                  overrun_q, overrun_n;
   logic                                  load;
   logic                                  transfer;
   logic                                  at_last;

   assign transfer = (state_q == STREAM) && m_ready_i;
   assign at_last  = (row_q == LAST_IDX) && (col_q == LAST_IDX);

   always_ff @(posedge clock or negedge nreset) begin
      if (!nreset) begin
         state_q   <= IDLE;
         buffer_q  <= '0;
         row_q     <= '0;
         col_q     <= '0;
         data_q    <= '0;
         last_q    <= 1'b0;
         overrun_q <= 1'b0;
      end else begin
         state_q   <= state_n;
         if (load) begin
            buffer_q <= matrix_i;
         end
         row_q     <= row_n;
         col_q     <= col_n;
         data_q    <= data_n;
         last_q    <= last_n;
         overrun_q <= overrun_n;
      end
   end

   always_comb begin
      state_n   = state_q;
      row_n     = row_q;
      col_n     = col_q;
      load      = 1'b0;
      overrun_n = 1'b0;

      case (state_q)
         IDLE: begin
            if (capture_i) begin
               load    = 1'b1;
               row_n   = '0;
               col_n   = '0;
               state_n = STREAM;
            end
         end
         STREAM: begin
            if (transfer) begin
               if (at_last) begin
                  // A capture landing on the final beat reloads with no bubble.
                  if (capture_i) begin
                     load  = 1'b1;
                     row_n = '0;
                     col_n = '0;
                  end else begin
                     state_n = IDLE;
                  end
               end else if (col_q == LAST_IDX) begin
                  col_n = '0;
                  row_n = row_q + 1'b1;
               end else begin
                  col_n = col_q + 1'b1;
               end
            end
            // Any other capture while streaming is dropped and flagged.
            if (capture_i && !(transfer && at_last)) begin
               overrun_n = 1'b1;
            end
         end
         default: state_n = IDLE;
      endcase
   end

   // The output element is registered: it is looked up from the buffer at the
   // next indices, or straight from matrix_i when the buffer is being loaded.
   always_comb begin
      data_n = data_q;
      if (load) begin
         data_n = matrix_i[0][0];
      end else if (state_n == STREAM) begin
         data_n = buffer_q[row_n][col_n];
      end
      last_n = (state_n == STREAM) && (row_n == LAST_IDX) && (col_n == LAST_IDX);
   end

   assign m_valid_o = (state_q == STREAM);
   assign busy_o    = (state_q == STREAM);
   assign m_data_o  = data_q;
   assign m_row_o   = row_q;
   assign m_col_o   = col_q;
   assign m_last_o  = last_q;
   assign overrun_o = overrun_q;
   assign state_o   = state_q;

endmodule

// File: tb/tb_matrix_result_serializer.sv
// -----------------------------------------------------------------------------
// tb_matrix_result_serializer
//   Self-checking bench. The reference model is a queue of expected beats
//   {row, col, data}: an accepted capture appends all SIZE*SIZE elements in
//   row-major order, a handshake pops the front. A capture is accepted when
//   nothing is pending, or when the only pending beat transfers that cycle.
// -----------------------------------------------------------------------------
module tb_matrix_result_serializer;
   import systolic_pkg::*;

   localparam int WIDTH = 4;
   localparam int SIZE  = 2;
   localparam int IW    = idx_width(SIZE);
   localparam int EW    = 2 * IW + WIDTH;

   logic                                 clock;
   logic                                 nreset;
   logic                                 capture_i;
   logic [SIZE-1:0][SIZE-1:0][WIDTH-1:0] matrix_i;
   logic                                 m_valid_o;
   logic                                 m_ready_i;
   logic [WIDTH-1:0]                     m_data_o;
   logic [IW-1:0]                        m_row_o;
   logic [IW-1:0]                        m_col_o;
   logic                                 m_last_o;
   logic                                 busy_o;
   logic                                 overrun_o;
   logic                                 state_o;

   matrix_result_serializer #(.WIDTH(WIDTH), .SIZE(SIZE)) dut (
      .clock     (clock),
      .nreset    (nreset),
      .capture_i (capture_i),
      .matrix_i  (matrix_i),
      .m_valid_o (m_valid_o),
      .m_ready_i (m_ready_i),
      .m_data_o  (m_data_o),
      .m_row_o   (m_row_o),
      .m_col_o   (m_col_o),
      .m_last_o  (m_last_o),
      .busy_o    (busy_o),
      .overrun_o (overrun_o),
      .state_o   (state_o)
   );

   // ---------------- clock / reset ----------------
   initial clock = 1'b0;
   always #5 clock = ~clock;

   // ---------------- scoreboard state ----------------
   logic [EW-1:0]                        exp_q[$];
   logic [WIDTH-1:0]                     last_data;
   logic                                 exp_ovr;
   logic [SIZE-1:0][SIZE-1:0][WIDTH-1:0] mat;
   int                                   n_compared;
   int                                   n_mismatched;
   int                                   valid_count;
   int                                   ovr_count;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_compared++;
      if (got !== exp) begin
         n_mismatched++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic check_outputs();
      logic [EW-1:0] e;
      logic          busy_exp;
      busy_exp = (exp_q.size() > 0);
      check_val("valid", 32'(m_valid_o), 32'(busy_exp));
      check_val("busy", 32'(busy_o), 32'(busy_exp));
      check_val("state", 32'(state_o), 32'(busy_exp));
      check_val("overrun", 32'(overrun_o), 32'(exp_ovr));
      if (m_valid_o) valid_count++;
      if (overrun_o) ovr_count++;
      if (busy_exp) begin
         e = exp_q[0];
         check_val("data", 32'(m_data_o), 32'(e[WIDTH-1:0]));
         check_val("row", 32'(m_row_o), 32'(e[EW-1 -: IW]));
         check_val("col", 32'(m_col_o), 32'(e[WIDTH+IW-1 -: IW]));
         check_val("last", 32'(m_last_o),
                   32'((e[EW-1 -: IW] == IW'(SIZE-1)) && (e[WIDTH+IW-1 -: IW] == IW'(SIZE-1))));
      end else begin
         check_val("idle_last", 32'(m_last_o), 32'(0));
         check_val("idle_data", 32'(m_data_o), 32'(last_data));
      end
   endtask

   // Advance the model across one rising edge with the given inputs.
   task automatic model_update(input logic cap, input logic rdy);
      logic [EW-1:0] e;
      logic          busy;
      logic          accept;
      busy    = (exp_q.size() > 0);
      exp_ovr = 1'b0;
      if (busy && rdy) begin
         e         = exp_q.pop_front();
         last_data = e[WIDTH-1:0];
      end
      accept = cap && (!busy || (rdy && exp_q.size() == 0));
      if (accept) begin
         for (int r = 0; r < SIZE; r++)
            for (int c = 0; c < SIZE; c++)
               exp_q.push_back({IW'(r), IW'(c), mat[r][c]});
      end else if (cap) begin
         exp_ovr = 1'b1;
      end
   endtask

   // ---------------- driver tasks ----------------
   // Called at a falling edge: check, drive, model the next rising edge.
   task automatic step(input logic cap, input logic rdy);
      check_outputs();
      capture_i = cap;
      m_ready_i = rdy;
      matrix_i  = mat;
      model_update(cap, rdy);
      @(posedge clock);
      @(negedge clock);
   endtask

   task automatic set_seq(input int base);
      for (int r = 0; r < SIZE; r++)
         for (int c = 0; c < SIZE; c++)
            mat[r][c] = WIDTH'(base + r * SIZE + c);
   endtask

   task automatic set_all(input int v);
      for (int r = 0; r < SIZE; r++)
         for (int c = 0; c < SIZE; c++)
            mat[r][c] = WIDTH'(v);
   endtask

   task automatic set_rand();
      for (int r = 0; r < SIZE; r++)
         for (int c = 0; c < SIZE; c++)
            mat[r][c] = WIDTH'($urandom_range(0, (1 << WIDTH) - 1));
   endtask

   // Asserts reset between edges and expects an immediate abort.
   task automatic do_reset();
      capture_i = 1'b0;
      m_ready_i = 1'b0;
      nreset    = 1'b0;
      #1;
      exp_q.delete();
      last_data = '0;
      exp_ovr   = 1'b0;
      check_outputs();
      check_val("rst_row", 32'(m_row_o), 32'(0));
      check_val("rst_col", 32'(m_col_o), 32'(0));
      @(posedge clock);
      @(negedge clock);
      nreset = 1'b1;
   endtask

   // ---------------- stimulus ----------------
   initial begin
      n_compared   = 0;
      n_mismatched = 0;
      valid_count  = 0;
      ovr_count    = 0;
      nreset       = 1'b0;
      capture_i    = 1'b0;
      m_ready_i    = 1'b0;
      matrix_i     = '0;
      mat          = '0;
      exp_q.delete();
      last_data    = '0;
      exp_ovr      = 1'b0;

      @(negedge clock);
      do_reset();

      // Basic stream, ready always high.
      set_seq(1);
      valid_count = 0;
      step(1'b1, 1'b1);
      for (int i = 0; i < 5; i++) step(1'b0, 1'b1);
      check_val("basic_valid_cycles", 32'(valid_count), 32'(4));

      // Backpressure for 3 cycles on element 2.
      set_seq(1);
      valid_count = 0;
      step(1'b1, 1'b1);
      step(1'b0, 1'b1);
      for (int i = 0; i < 3; i++) step(1'b0, 1'b0);
      for (int i = 0; i < 4; i++) step(1'b0, 1'b1);
      check_val("bp_valid_cycles", 32'(valid_count), 32'(7));

      // Back-to-back capture on the last beat.
      set_seq(1);
      valid_count = 0;
      step(1'b1, 1'b1);
      for (int i = 0; i < 3; i++) step(1'b0, 1'b1);
      set_seq(5);
      step(1'b1, 1'b1);
      for (int i = 0; i < 5; i++) step(1'b0, 1'b1);
      check_val("b2b_valid_cycles", 32'(valid_count), 32'(8));

      // Overrun during beat 2.
      set_seq(1);
      ovr_count = 0;
      step(1'b1, 1'b1);
      step(1'b0, 1'b1);
      set_all(9);
      step(1'b1, 1'b1);
      for (int i = 0; i < 4; i++) step(1'b0, 1'b1);
      check_val("overrun_pulses", 32'(ovr_count), 32'(1));

      // Reset after beat 2, then a fresh capture.
      set_seq(1);
      step(1'b1, 1'b1);
      step(1'b0, 1'b1);
      step(1'b0, 1'b1);
      do_reset();
      set_seq(3);
      step(1'b1, 1'b1);
      for (int i = 0; i < 5; i++) step(1'b0, 1'b1);

      // Randomized traffic with occasional resets.
      for (int i = 0; i < 600; i++) begin
         set_rand();
         if ($urandom_range(0, 199) == 0) begin
            do_reset();
         end else begin
            step(($urandom_range(0, 4) == 0), ($urandom_range(0, 3) != 0));
         end
      end

      // Drain.
      for (int i = 0; i < 2 * SIZE * SIZE + 2; i++) step(1'b0, 1'b1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
      $finish;
   end

endmodule
